mem_wb_skid_reg: RTL and testbench

- Parametrised successor to the MEM/WB pipeline register for the pipelined ARM-subset core.
- Carries the write-back bundle from the MEM stage to the WB stage: wb_en, mem_r_en, ALU result, memory read data and destination register.
- Adds a valid/ready handshake with an optional 2-entry skid buffer, a synchronous flush that inserts a bubble, and a saturating stall counter, so the WB stage can back-pressure MEM without a combinational ready path.

---
 rtl/core_pkg.sv | 28 ++
 rtl/skid_buf_2.sv | 100 ++++++++++
 rtl/mem_wb_skid_reg.sv | 71 +++++++
 tb/tb_mem_wb_skid_reg.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and defaults for the MEM/WB write-back path.
package core_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEST_W_DEF = 4;

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic [DATA_W_DEF-1:0] alu_res;
    logic [DATA_W_DEF-1:0] mem;
    logic [DEST_W_DEF-1:0] dest;
  } wb_bundle_t;

  localparam int unsigned PAYLOAD_W = $bits(wb_bundle_t);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } skid_state_e;

  function automatic int unsigned payload_w(input int unsigned data_w,
                                            input int unsigned dest_w);
    return 2 + 2 * data_w + dest_w;
  endfunction

endpackage

// File: rtl/skid_buf_2.sv
// Generic valid/ready buffer: 2-entry skid (registered ready) or single register.
module skid_buf_2
  import core_pkg::*;
#(
  parameter int unsigned W    = PAYLOAD_W,
  parameter bit          SKID = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic         accept, drain;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = main_q;
  assign drain       = out_valid_o & out_ready_i;
  assign accept      = in_valid_i & in_ready_o;

  if (SKID) begin : g_skid
    logic [W-1:0] skid_q, skid_d;

    assign in_ready_o = !rst_i && (state_q != ST_FULL);

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_i) begin
        state_d = ST_EMPTY;
      end else begin
        unique case (state_q)
          ST_EMPTY: begin
            if (accept) begin
              main_d  = in_data_i;
              state_d = ST_ONE;
            end
          end
          ST_ONE: begin
            if (accept && drain) begin
              main_d = in_data_i;
            end else if (accept) begin
              skid_d  = in_data_i;
              state_d = ST_FULL;
            end else if (drain) begin
              state_d = ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (drain) begin
              main_d  = skid_q;
              state_d = ST_ONE;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) skid_q <= '0;
      else       skid_q <= skid_d;
    end
  end else begin : g_noskid
    assign in_ready_o = !rst_i && (!out_valid_o || out_ready_i);

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      if (flush_i) begin
        state_d = ST_EMPTY;
      end else if (accept) begin
        main_d  = in_data_i;
        state_d = ST_ONE;
      end else if (drain) begin
        state_d = ST_EMPTY;
      end
    end
  end

  // Flush only resets occupancy; held data stays visible (but invalid).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register with valid/ready handshake, flush and stall counter.
module mem_wb_skid_reg
  import core_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEST_W = DEST_W_DEF,
  parameter bit          SKID   = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              WB_EN_in,
  input  logic              MEM_R_EN_in,
  input  logic [DATA_W-1:0] ALU_res_in,
  input  logic [DATA_W-1:0] mem_in,
  input  logic [DEST_W-1:0] Dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              WB_EN_out,
  output logic              MEM_R_EN_out,
  output logic [DATA_W-1:0] ALU_res_out,
  output logic [DATA_W-1:0] mem_out,
  output logic [DEST_W-1:0] Dest_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned PW = payload_w(DATA_W, DEST_W);

  logic [PW-1:0]    in_pl, out_pl;
  logic [CNT_W-1:0] stall_q, stall_d;

  assign in_pl = {WB_EN_in, MEM_R_EN_in, ALU_res_in, mem_in, Dest_in};

  skid_buf_2 #(
    .W    (PW),
    .SKID (SKID)
  ) u_buf (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_pl),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_pl)
  );

  // Control bits are qualified by valid so a stale entry never writes back.
  assign WB_EN_out    = out_valid & out_pl[PW-1];
  assign MEM_R_EN_out = out_valid & out_pl[PW-2];
  assign ALU_res_out  = out_pl[DEST_W+DATA_W +: DATA_W];
  assign mem_out      = out_pl[DEST_W +: DATA_W];
  assign Dest_out     = out_pl[DEST_W-1:0];

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Bench for mem_wb_skid_reg: SKID=1/CNT_W=4 and SKID=0/CNT_W=16 against a FIFO model.
module tb_mem_wb_skid_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        wb_in, mr_in;
  logic [31:0] alu_in, mem_in_s;
  logic [3:0]  dest_in;

  logic        in_ready_1, out_valid_1, wb_1, mr_1;
  logic [31:0] alu_1, mem_1;
  logic [3:0]  dest_1;
  logic [3:0]  sc_1;
  logic        in_ready_0, out_valid_0, wb_0, mr_0;
  logic [31:0] alu_0, mem_0;
  logic [3:0]  dest_0;
  logic [15:0] sc_0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model: index 1 = SKID=1 instance (capacity 2), index 0 = SKID=0 (capacity 1).
  bit [69:0]   m_buf  [2][2];
  int unsigned m_n    [2];
  bit [69:0]   m_held [2];
  int unsigned m_cnt  [2];
  int unsigned m_max  [2];

  always #5 clk = ~clk;

  mem_wb_skid_reg #(.DATA_W(32), .DEST_W(4), .SKID(1'b1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_1),
    .WB_EN_in(wb_in), .MEM_R_EN_in(mr_in), .ALU_res_in(alu_in), .mem_in(mem_in_s),
    .Dest_in(dest_in), .out_valid(out_valid_1), .out_ready(out_ready),
    .WB_EN_out(wb_1), .MEM_R_EN_out(mr_1), .ALU_res_out(alu_1), .mem_out(mem_1),
    .Dest_out(dest_1), .stall_cnt(sc_1)
  );

  mem_wb_skid_reg #(.DATA_W(32), .DEST_W(4), .SKID(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_0),
    .WB_EN_in(wb_in), .MEM_R_EN_in(mr_in), .ALU_res_in(alu_in), .mem_in(mem_in_s),
    .Dest_in(dest_in), .out_valid(out_valid_0), .out_ready(out_ready),
    .WB_EN_out(wb_0), .MEM_R_EN_out(mr_0), .ALU_res_out(alu_0), .mem_out(mem_0),
    .Dest_out(dest_0), .stall_cnt(sc_0)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_ir(input int d);
    if (rst) return 1'b0;
    if (d == 1) return m_n[d] < 2;
    return (m_n[d] == 0) || out_ready;
  endfunction

  task automatic model_edge(input int d);
    bit [69:0] inp;
    bit acc, dr;
    inp = {wb_in, mr_in, alu_in, mem_in_s, dest_in};
    acc = in_valid && m_ir(d);
    dr  = (m_n[d] > 0) && out_ready;
    if (rst) begin
      m_n[d] = 0; m_held[d] = '0; m_cnt[d] = 0;
      return;
    end
    if ((m_n[d] > 0) && !out_ready && (m_cnt[d] < m_max[d])) m_cnt[d]++;
    if (flush) begin
      m_n[d] = 0;
    end else begin
      if (dr) begin
        m_buf[d][0] = m_buf[d][1];
        m_n[d]--;
      end
      if (acc) begin
        m_buf[d][m_n[d]] = inp;
        m_n[d]++;
      end
    end
    if (m_n[d] > 0) m_held[d] = m_buf[d][0];
  endtask

  task automatic check_dut(input int d, input logic ov, input logic ir, input logic wb,
                           input logic mr, input logic [31:0] alu, input logic [31:0] mem,
                           input logic [3:0] dest, input logic [15:0] sc);
    bit        ev;
    bit [69:0] ep;
    ev = m_n[d] > 0;
    ep = ev ? m_buf[d][0] : m_held[d];
    cmp($sformatf("d%0d.out_valid", d), 32'(ov), 32'(ev));
    cmp($sformatf("d%0d.in_ready", d), 32'(ir), 32'(m_ir(d)));
    cmp($sformatf("d%0d.WB_EN_out", d), 32'(wb), 32'(ev & ep[69]));
    cmp($sformatf("d%0d.MEM_R_EN_out", d), 32'(mr), 32'(ev & ep[68]));
    cmp($sformatf("d%0d.ALU_res_out", d), alu, ep[67:36]);
    cmp($sformatf("d%0d.mem_out", d), mem, ep[35:4]);
    cmp($sformatf("d%0d.Dest_out", d), 32'(dest), 32'(ep[3:0]));
    cmp($sformatf("d%0d.stall_cnt", d), 32'(sc), m_cnt[d]);
  endtask

  // One clock: check pre-edge outputs against the model, advance the model, take the edge.
  task automatic step();
    @(negedge clk);
    check_dut(1, out_valid_1, in_ready_1, wb_1, mr_1, alu_1, mem_1, dest_1, {12'b0, sc_1});
    check_dut(0, out_valid_0, in_ready_0, wb_0, mr_0, alu_0, mem_0, dest_0, sc_0);
    model_edge(1);
    model_edge(0);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit ordy, input bit fl, input bit wb, input bit mr,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [3:0] dest);
    in_valid = v; out_ready = ordy; flush = fl;
    wb_in = wb; mr_in = mr; alu_in = alu; mem_in_s = mem; dest_in = dest;
    step();
  endtask

  initial begin
    m_max[0] = 65535; m_max[1] = 15;
    for (int d = 0; d < 2; d++) begin
      m_n[d] = 0; m_held[d] = '0; m_cnt[d] = 0;
    end
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    wb_in = 1'b1; mr_in = 1'b1; alu_in = 32'h1234; mem_in_s = 32'h5678; dest_in = 4'h9;
    @(posedge clk);
    #1;

    // Reset held with in_valid high.
    drive(1, 0, 0, 1, 1, 32'h1234, 32'h5678, 4'h9);
    drive(1, 0, 0, 1, 1, 32'h1234, 32'h5678, 4'h9);
    rst = 1'b0;
    drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++)
      drive(1, 1, 0, i[0], 0, 32'h100 + 32'(i), $urandom, 4'(i));
    drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);

    // Back-pressure: A held, B goes to skid, then both drain in order.
    drive(1, 1, 0, 1, 0, 32'hA, 32'hAA, 4'd3);
    drive(1, 0, 0, 1, 0, 32'hB, 32'hBB, 4'd5);
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);

    // Flush while FULL with C offered in the same cycle.
    drive(1, 1, 0, 1, 1, 32'hA1, 32'hA2, 4'd3);
    drive(1, 0, 0, 1, 1, 32'hB1, 32'hB2, 4'd5);
    drive(1, 0, 1, 1, 1, 32'hC1, 32'hC2, 4'd7);
    drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    cmp("flush.out_valid", 32'(out_valid_1), 32'd0);
    cmp("flush.in_ready", 32'(in_ready_1), 32'd1);
    drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);

    // Load path, then an idle cycle drops WB_EN_out.
    drive(1, 1, 0, 1, 1, 32'h40, 32'hDEADBEEF, 4'hE);
    drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);

    // Saturation of the 4-bit stall counter.
    drive(1, 1, 0, 1, 0, 32'h55, 32'h66, 4'd2);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    cmp("sat.stall_cnt", 32'(sc_1), 32'd15);
    drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    cmp("sat.hold", 32'(sc_1), 32'd15);

    // Random traffic with occasional flush.
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0, 1'($urandom), 1'($urandom),
            $urandom, $urandom, 4'($urandom));

    // Reset again mid-traffic.
    rst = 1'b1;
    drive(1, 0, 0, 1, 1, 32'h77, 32'h88, 4'h1);
    rst = 1'b0;
    drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
